// File: rtl/sdspi_perf_monitor.sv
// Passive performance monitor for the SD-SPI block. It watches the UUT start/finish/err handshake and
// the SPI bus, counting cycles, SCLK rising edges and whole bytes per run, and holds the results for readout.
module sdspi_perf_monitor #(
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 32'd100_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 finish,
  input  logic                 err,
  input  logic                 cs,
  input  logic                 sclk,
  input  logic                 mosi,
  input  logic                 miso,
  input  logic [1:0]           rd_sel,
  output logic [CNT_WIDTH-1:0] rd_data,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic                 uut_err,
  output logic [7:0]           last_miso_byte,
  output logic [7:0]           last_mosi_byte
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StMeasure = 2'd1,
    StDone    = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] TimeoutLast = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CntMax      = {CNT_WIDTH{1'b1}};

  state_e               state_q, state_d;
  logic                 start_q, finish_q, sclk_q;
  logic [CNT_WIDTH-1:0] cycles_q, cycles_d;
  logic [CNT_WIDTH-1:0] sclk_edges_q, sclk_edges_d;
  logic [CNT_WIDTH-1:0] bytes_q, bytes_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]           miso_sr_q, miso_sr_d;
  logic [7:0]           mosi_sr_q, mosi_sr_d;
  logic [7:0]           last_miso_q, last_miso_d;
  logic [7:0]           last_mosi_q, last_mosi_d;
  logic                 timeout_q, timeout_d;
  logic                 uut_err_q, uut_err_d;

  logic                 start_rise, finish_rise, sclk_rise;
  logic [31:0]          status_w;

  assign start_rise  = start & ~start_q;
  assign finish_rise = finish & ~finish_q;
  assign sclk_rise   = sclk & ~sclk_q;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CntMax) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_comb begin
    state_d      = state_q;
    cycles_d     = cycles_q;
    sclk_edges_d = sclk_edges_q;
    bytes_d      = bytes_q;
    bit_cnt_d    = bit_cnt_q;
    miso_sr_d    = miso_sr_q;
    mosi_sr_d    = mosi_sr_q;
    last_miso_d  = last_miso_q;
    last_mosi_d  = last_mosi_q;
    timeout_d    = timeout_q;
    uut_err_d    = uut_err_q;

    case (state_q)
      StIdle, StDone: begin
        // A start edge here also swallows a coincident finish edge.
        if (start_rise) begin
          state_d      = StMeasure;
          cycles_d     = '0;
          sclk_edges_d = '0;
          bytes_d      = '0;
          bit_cnt_d    = '0;
          miso_sr_d    = '0;
          mosi_sr_d    = '0;
          timeout_d    = 1'b0;
          uut_err_d    = 1'b0;
        end
      end

      StMeasure: begin
        cycles_d = sat_inc(cycles_q);
        if (sclk_rise) begin
          sclk_edges_d = sat_inc(sclk_edges_q);
        end

        if (cs) begin
          bit_cnt_d = '0;
        end else if (sclk_rise) begin
          miso_sr_d = {miso_sr_q[6:0], miso};
          mosi_sr_d = {mosi_sr_q[6:0], mosi};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            bytes_d     = sat_inc(bytes_q);
            last_miso_d = {miso_sr_q[6:0], miso};
            last_mosi_d = {mosi_sr_q[6:0], mosi};
          end
        end

        if (err) begin
          state_d   = StDone;
          uut_err_d = 1'b1;
        end else if (finish_rise) begin
          state_d = StDone;
        end else if (cycles_q == TimeoutLast) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      start_q      <= 1'b0;
      finish_q     <= 1'b0;
      sclk_q       <= 1'b0;
      cycles_q     <= '0;
      sclk_edges_q <= '0;
      bytes_q      <= '0;
      bit_cnt_q    <= '0;
      miso_sr_q    <= '0;
      mosi_sr_q    <= '0;
      last_miso_q  <= '0;
      last_mosi_q  <= '0;
      timeout_q    <= 1'b0;
      uut_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start;
      finish_q     <= finish;
      sclk_q       <= sclk;
      cycles_q     <= cycles_d;
      sclk_edges_q <= sclk_edges_d;
      bytes_q      <= bytes_d;
      bit_cnt_q    <= bit_cnt_d;
      miso_sr_q    <= miso_sr_d;
      mosi_sr_q    <= mosi_sr_d;
      last_miso_q  <= last_miso_d;
      last_mosi_q  <= last_mosi_d;
      timeout_q    <= timeout_d;
      uut_err_q    <= uut_err_d;
    end
  end

  assign status_w = {state_q, timeout_q, uut_err_q, 20'b0, last_miso_q};

  always_comb begin
    rd_data = '0;
    case (rd_sel)
      2'd0:    rd_data = cycles_q;
      2'd1:    rd_data = sclk_edges_q;
      2'd2:    rd_data = bytes_q;
      default: rd_data = CNT_WIDTH'(status_w);
    endcase
  end

  assign busy           = (state_q == StMeasure);
  assign done           = (state_q == StDone);
  assign timeout        = timeout_q;
  assign uut_err        = uut_err_q;
  assign last_miso_byte = last_miso_q;
  assign last_mosi_byte = last_mosi_q;

endmodule

// File: tb/tb_sdspi_perf_monitor.sv
// Directed bench for sdspi_perf_monitor: a long-timeout instance and a 50-cycle-timeout instance
// share the same stimulus; each task checks one scenario against hand-computed values.
module tb_sdspi_perf_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, finish = 1'b0, err = 1'b0;
  logic        cs = 1'b1, sclk = 1'b0, mosi = 1'b0, miso = 1'b0;
  logic [1:0]  rd_sel = 2'd0;

  logic [31:0] rd_data, rd_data_to;
  logic        busy, done, timeout, uut_err;
  logic        busy_to, done_to, timeout_to, uut_err_to;
  logic [7:0]  last_miso, last_mosi, last_miso_to, last_mosi_to;

  int n_checks = 0;
  int n_fail   = 0;

  sdspi_perf_monitor #(.CNT_WIDTH(32), .TIMEOUT_CYCLES(32'd100_000_000)) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish), .err(err),
    .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso), .rd_sel(rd_sel),
    .rd_data(rd_data), .busy(busy), .done(done), .timeout(timeout), .uut_err(uut_err),
    .last_miso_byte(last_miso), .last_mosi_byte(last_mosi)
  );

  sdspi_perf_monitor #(.CNT_WIDTH(32), .TIMEOUT_CYCLES(32'd50)) dut_to (
    .clk(clk), .rst(rst), .start(start), .finish(finish), .err(err),
    .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso), .rd_sel(rd_sel),
    .rd_data(rd_data_to), .busy(busy_to), .done(done_to), .timeout(timeout_to),
    .uut_err(uut_err_to), .last_miso_byte(last_miso_to), .last_mosi_byte(last_mosi_to)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] sel, output logic [31:0] v, output logic [31:0] v_to);
    rd_sel = sel;
    #1;
    v    = rd_data;
    v_to = rd_data_to;
  endtask

  // One SCLK rising edge over two cycles; data is valid at the rising edge.
  task automatic rise(input logic mi, input logic mo);
    sclk = 1'b0;
    step();
    sclk = 1'b1;
    miso = mi;
    mosi = mo;
    step();
  endtask

  task automatic test_reset();
    logic [31:0] v, vt;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start = 1'($urandom); finish = 1'($urandom); err = 1'($urandom);
      cs = 1'($urandom); sclk = 1'($urandom); miso = 1'($urandom); mosi = 1'($urandom);
      step();
    end
    n_checks++; if ({busy, done, timeout, uut_err} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, timeout, uut_err}); end
    n_checks++; if ({last_miso, last_mosi} !== 16'h0) begin
      n_fail++; $display("FAIL reset_last_bytes: got %h expected 0000", {last_miso, last_mosi}); end
    n_checks++; if ({busy_to, done_to, timeout_to, uut_err_to} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags_to: got %b expected 0000",
                         {busy_to, done_to, timeout_to, uut_err_to}); end
    for (int s = 0; s < 4; s++) begin
      rd(2'(s), v, vt);
      n_checks++; if (v !== 32'h0 || vt !== 32'h0) begin
        n_fail++; $display("FAIL reset_rd_data sel=%0d: got %h/%h expected 0", s, v, vt); end
    end
    start = 0; finish = 0; err = 0; cs = 1; sclk = 0; miso = 0; mosi = 0;
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic_run();
    logic [31:0] v, vt;
    logic [7:0]  pm, po;
    pm = 8'hA5;
    po = 8'h3C;
    start = 1'b1;
    step();
    n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL basic_busy_after_start: got busy=%b done=%b expected 1/0", busy, done); end
    cs = 1'b0;
    for (int r = 0; r < 80; r++) rise(pm[7 - (r % 8)], po[7 - (r % 8)]);
    for (int i = 0; i < 839; i++) step();
    n_checks++; if (busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_busy_before_finish: got %b expected 1", busy); end
    finish = 1'b1;
    step();
    n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_done: got done=%b busy=%b expected 1/0", done, busy); end
    rd(2'd0, v, vt);
    n_checks++; if (v !== 32'd1000) begin
      n_fail++; $display("FAIL basic_cycles: got %0d expected 1000", v); end
    rd(2'd1, v, vt);
    n_checks++; if (v !== 32'd80) begin
      n_fail++; $display("FAIL basic_sclk_edges: got %0d expected 80", v); end
    rd(2'd2, v, vt);
    n_checks++; if (v !== 32'd10) begin
      n_fail++; $display("FAIL basic_bytes: got %0d expected 10", v); end
    rd(2'd3, v, vt);
    n_checks++; if (v !== 32'h8000_00A5) begin
      n_fail++; $display("FAIL basic_status: got %h expected 800000a5", v); end
    n_checks++; if (last_miso !== 8'hA5 || last_mosi !== 8'h3C) begin
      n_fail++; $display("FAIL basic_last_bytes: got %h/%h expected a5/3c", last_miso, last_mosi); end
    start = 1'b0; finish = 1'b0;
    step();
    step();
    rd(2'd0, v, vt);
    n_checks++; if (v !== 32'd1000 || done !== 1'b1) begin
      n_fail++; $display("FAIL basic_hold: got cycles=%0d done=%b expected 1000/1", v, done); end
  endtask

  task automatic test_partial_byte();
    logic [31:0] v, vt;
    logic [7:0]  a, b;
    a = 8'h11;
    b = 8'h5A;
    start = 1'b1;
    step();
    rd(2'd0, v, vt);
    n_checks++; if (v !== 32'd0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL restart_clear: got cycles=%0d busy=%b expected 0/1", v, busy); end
    cs = 1'b0;
    for (int r = 0; r < 8; r++) rise(a[7 - r], ~a[7 - r]);
    for (int r = 0; r < 4; r++) rise(1'b1, 1'b1);
    cs = 1'b1;
    step();
    cs = 1'b0;
    for (int r = 0; r < 8; r++) rise(b[7 - r], ~b[7 - r]);
    // A second start edge mid-run must not restart the measurement.
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    finish = 1'b1;
    step();
    n_checks++; if (done !== 1'b1) begin
      n_fail++; $display("FAIL partial_done: got %b expected 1", done); end
    rd(2'd0, v, vt);
    n_checks++; if (v !== 32'd44) begin
      n_fail++; $display("FAIL partial_cycles: got %0d expected 44", v); end
    rd(2'd1, v, vt);
    n_checks++; if (v !== 32'd20) begin
      n_fail++; $display("FAIL partial_sclk_edges: got %0d expected 20", v); end
    rd(2'd2, v, vt);
    n_checks++; if (v !== 32'd2) begin
      n_fail++; $display("FAIL partial_bytes: got %0d expected 2", v); end
    n_checks++; if (last_miso !== 8'h5A || last_mosi !== 8'hA5) begin
      n_fail++; $display("FAIL partial_last_bytes: got %h/%h expected 5a/a5", last_miso, last_mosi); end
    start = 1'b0; finish = 1'b0; cs = 1'b1;
    step();
  endtask

  task automatic test_timeout();
    logic [31:0] v, vt;
    start = 1'b1;
    step();
    for (int i = 0; i < 49; i++) step();
    n_checks++; if (busy_to !== 1'b1 || done_to !== 1'b0) begin
      n_fail++; $display("FAIL timeout_early: got busy=%b done=%b expected 1/0", busy_to, done_to); end
    step();
    n_checks++; if (done_to !== 1'b1 || timeout_to !== 1'b1 || uut_err_to !== 1'b0) begin
      n_fail++; $display("FAIL timeout_flags: got done=%b to=%b err=%b expected 1/1/0",
                         done_to, timeout_to, uut_err_to); end
    rd(2'd0, v, vt);
    n_checks++; if (vt !== 32'd50) begin
      n_fail++; $display("FAIL timeout_cycles: got %0d expected 50", vt); end
    rd(2'd3, v, vt);
    n_checks++; if (vt[31:28] !== 4'b1010) begin
      n_fail++; $display("FAIL timeout_status: got %b expected 1010", vt[31:28]); end
    n_checks++; if (busy !== 1'b1 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL timeout_long_instance: got busy=%b to=%b expected 1/0", busy, timeout); end
    for (int i = 0; i < 3; i++) step();
    rd(2'd0, v, vt);
    n_checks++; if (vt !== 32'd50) begin
      n_fail++; $display("FAIL timeout_hold: got %0d expected 50", vt); end
    finish = 1'b1;
    step();
    rd(2'd0, v, vt);
    n_checks++; if (done !== 1'b1 || v !== 32'd54) begin
      n_fail++; $display("FAIL timeout_long_finish: got done=%b cycles=%0d expected 1/54", done, v); end
    start = 1'b0; finish = 1'b0;
    step();
  endtask

  task automatic test_err_priority();
    logic [31:0] v, vt;
    start = 1'b1;
    step();
    for (int i = 0; i < 19; i++) step();
    err = 1'b1; finish = 1'b1;
    step();
    n_checks++; if (done !== 1'b1 || uut_err !== 1'b1 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL errprio_flags: got done=%b err=%b to=%b expected 1/1/0",
                         done, uut_err, timeout); end
    rd(2'd0, v, vt);
    n_checks++; if (v !== 32'd20) begin
      n_fail++; $display("FAIL errprio_cycles: got %0d expected 20", v); end
    rd(2'd3, v, vt);
    n_checks++; if (v[31:28] !== 4'b1001) begin
      n_fail++; $display("FAIL errprio_status: got %b expected 1001", v[31:28]); end
    err = 1'b0; finish = 1'b0; start = 1'b0;
    step();
  endtask

  task automatic test_err_at_start();
    logic [31:0] v, vt;
    err = 1'b1; start = 1'b1;
    step();
    n_checks++; if (busy !== 1'b1 || uut_err !== 1'b0) begin
      n_fail++; $display("FAIL errstart_begin: got busy=%b err=%b expected 1/0", busy, uut_err); end
    step();
    rd(2'd0, v, vt);
    n_checks++; if (done !== 1'b1 || uut_err !== 1'b1 || v !== 32'd1) begin
      n_fail++; $display("FAIL errstart_end: got done=%b err=%b cycles=%0d expected 1/1/1",
                         done, uut_err, v); end
    err = 1'b0; start = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] v, vt;
    start = 1'b1; finish = 1'b1;
    step();
    n_checks++; if (busy !== 1'b1 || uut_err !== 1'b0) begin
      n_fail++; $display("FAIL b2b_start_wins: got busy=%b err=%b expected 1/0", busy, uut_err); end
    step();
    rd(2'd0, v, vt);
    n_checks++; if (busy !== 1'b1 || v !== 32'd1) begin
      n_fail++; $display("FAIL b2b_finish_consumed: got busy=%b cycles=%0d expected 1/1", busy, v); end
    finish = 1'b0;
    step();
    finish = 1'b1;
    step();
    rd(2'd0, v, vt);
    n_checks++; if (done !== 1'b1 || v !== 32'd3) begin
      n_fail++; $display("FAIL b2b_end: got done=%b cycles=%0d expected 1/3", done, v); end
    start = 1'b0; finish = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] v, vt;
    start = 1'b1;
    step();
    cs = 1'b0;
    for (int r = 0; r < 4; r++) rise(1'b1, 1'b1);
    for (int i = 0; i < 21; i++) step();
    rst = 1'b0;
    step();
    n_checks++; if ({busy, done, timeout, uut_err} !== 4'b0) begin
      n_fail++; $display("FAIL midreset_flags: got %b expected 0000", {busy, done, timeout, uut_err}); end
    n_checks++; if ({last_miso, last_mosi} !== 16'h0) begin
      n_fail++; $display("FAIL midreset_last_bytes: got %h expected 0000", {last_miso, last_mosi}); end
    for (int s = 0; s < 4; s++) begin
      rd(2'(s), v, vt);
      n_checks++; if (v !== 32'h0) begin
        n_fail++; $display("FAIL midreset_rd_data sel=%0d: got %h expected 0", s, v); end
    end
    start = 1'b0; cs = 1'b1;
    rst = 1'b1;
    step();
    start = 1'b1;
    step();
    for (int i = 0; i < 4; i++) step();
    finish = 1'b1;
    step();
    rd(2'd0, v, vt);
    n_checks++; if (done !== 1'b1 || v !== 32'd5) begin
      n_fail++; $display("FAIL postreset_run: got done=%b cycles=%0d expected 1/5", done, v); end
    start = 1'b0; finish = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_partial_byte();
    test_timeout();
    test_err_priority();
    test_err_at_start();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdspi_perf_monitor.md
# sdspi_perf_monitor

Passive measurement stage placed beside `sdspi_system` in the hardware-performance build. It observes the UUT control handshake (`start`/`finish`/`err`) and the SPI bus (`cs`/`sclk`/`mosi`/`miso`). Per run it counts clock cycles, SCLK rising edges and complete bytes transferred. It holds the results for `autotest_module` and the 7-segment debug path to read.

## Interface
Parameters:
- `CNT_WIDTH`, 32: width of every counter and of `rd_data`.
- `TIMEOUT_CYCLES`, 32'd100_000_000: measurement aborts when `cycles` reaches this value.

Ports:
- `clk` in 1: single clock. All inputs are synchronous to it; the UUT runs on the same clock.
- `rst` in 1: synchronous, active-low reset.
- `start` in 1: UUT start pulse/level. Only the rising edge is used.
- `finish` in 1: UUT finish. Only the rising edge is used.
- `err` in 1: UUT error. Level-sensitive.
- `cs` in 1: SPI chip select, active-low.
- `sclk` in 1: SPI clock as driven by the UUT.
- `mosi` in 1: SPI MOSI.
- `miso` in 1: SPI MISO.
- `rd_sel` in 2: readout select. 0 = cycles, 1 = sclk_edges, 2 = bytes, 3 = status word.
- `rd_data` out CNT_WIDTH: selected value. Combinational from registers.
- `busy` out 1: high while in MEASURE.
- `done` out 1: high while in DONE.
- `timeout` out 1: last run ended by timeout.
- `uut_err` out 1: last run ended by `err`.
- `last_miso_byte` out 8: last complete byte shifted in on MISO.
- `last_mosi_byte` out 8: last complete byte shifted out on MOSI.

## Operation
- Edge detection: `start_q`, `finish_q` and `sclk_q` are registered copies of their inputs.
  - start_rise = start & ~start_q
  - finish_rise = finish & ~finish_q
  - sclk_rise = sclk & ~sclk_q
- FSM states: IDLE, MEASURE, DONE.
  - IDLE → MEASURE on start_rise. All counters, the bit counter, `timeout` and `uut_err` clear.
  - MEASURE → DONE on finish_rise, or on `err`=1 (sets `uut_err`), or when `cycles` == TIMEOUT_CYCLES-1 at the edge (sets `timeout`).
    - Priority: err > finish > timeout. Only the highest-priority cause sets its flag.
  - MEASURE ignores start_rise.
  - DONE → MEASURE on start_rise, with the same clear as IDLE. Otherwise DONE holds all results.
- Counters update only in MEASURE, including on the edge that leaves MEASURE.
  - `cycles` += 1 every edge.
  - `sclk_edges` += 1 on sclk_rise.
  - Bit counter (3-bit) increments on sclk_rise while cs=0. MISO and MOSI are shifted MSB-first into 8-bit shifters on the same edge.
  - When the bit counter wraps 7→0, `bytes` += 1 and both shifters are copied to `last_*_byte`.
  - cs=1 resets the bit counter to 0 and discards the partial byte. `bytes` does not count it.
  - sclk_rise while cs=1 still counts in `sclk_edges`. This covers the SD init dummy clocks.
- All counters saturate at all-ones. No wrap-around.
- Status word on rd_sel=3: {state[1:0], timeout, uut_err, 20'b0, last_miso_byte}, zero-extended or truncated to CNT_WIDTH.

## Timing
- Reset values (edge with rst=0): state IDLE; `busy`, `done`, `timeout`, `uut_err` = 0; all counters, the bit counter and `last_*_byte` = 0; `start_q`, `finish_q`, `sclk_q` = 0.
- Reset mid-MEASURE aborts the run and restores all reset values on that edge.
- Start at edge E0 means `busy`=1 after E0. Finish at edge En means `done`=1 after En, and `cycles` = n.
- Simultaneous start_rise and finish_rise in IDLE/DONE: start wins. The finish edge is consumed, so it does not end the run.
- `err` already high at a start_rise edge: run starts, then ends on the next edge with `cycles`=1 and `uut_err`=1.
- `rd_data` follows `rd_sel` in the same cycle. There is no latency.

## Test plan
- Reset: drive rst=0 for 2 cycles with random inputs → all outputs 0, state IDLE, `rd_data`=0 for all rd_sel.
- Basic run: start rises at E0, finish rises at E1000, with cs=0 and 80 sclk rises (MISO pattern 0xA5 repeated) → `cycles`=1000, `sclk_edges`=80, `bytes`=10, `last_miso_byte`=0xA5, `done`=1.
- Partial byte: 12 sclk rises with cs=0, then cs=1, then 8 more rises with cs=0 → `bytes`=2, `sclk_edges`=20.
- Timeout with TIMEOUT_CYCLES=50 and finish never asserted → DONE after 50 edges, `cycles`=50, `timeout`=1, `uut_err`=0.
- Error priority: err and finish_rise on the same edge at E20 → `uut_err`=1, `timeout`=0, `cycles`=20.
- Restart and reset: start_rise in DONE → counters cleared, new run measured correctly. rst=0 at E30 of a run → immediate IDLE, all zeros.
